alu54d_acc_sched: RTL and testbench
===================================

// Module: alu54d_acc_sched
// PURPOSE
//  Round-robin scheduler sharing one ALU54D accumulate datapath among NREQ requesters.
//  A requester holds the accumulator across a burst from its first beat to its last beat; no other requester is granted meanwhile.
//  Sits between requester FSMs (e.g. DSP firmware bridge) and the ALU54D instance; one operation in flight at a time.
// PARAMETERS
//  NREQ     4     number of requesters (2..8)
//  DW       54    operand/result width (ALU54D A/B/DOUT)
//  LAT      1     cycles from ISSUE to alu_dout valid (>=1; ALU built AREG=BREG=0, OUT_REG=1)
//  TIMEOUT  255   idle cycles a lock owner may stall before forced release (watchdog only)
// PORTS
//  clk        in   1        clock
//  reset      in   1        asynchronous reset, active-low
//  req_valid  in   NREQ     beat request per requester
//  req_ready  out  NREQ     beat accepted (one-hot or zero)
//  req_a      in   NREQ*DW  operand A, requester i at [i*DW +: DW]
//  req_b      in   NREQ*DW  operand B, same packing
//  req_sign   in   NREQ*2   {bsign,asign} per requester
//  req_first  in   NREQ     beat loads accumulator (ACCLOAD=0)
//  req_last   in   NREQ     beat ends burst, releases lock
//  rsp_valid  out  1        result valid
//  rsp_ready  in   1        result consumer ready
//  rsp_data   out  DW       captured alu_dout
//  rsp_id     out  $clog2(NREQ) requester index of rsp_data
//  alu_a/alu_b out DW       ALU operands (registered)
//  alu_asign/alu_bsign out 1  ALU sign controls
//  alu_accload out 1        0 = load, 1 = accumulate
//  alu_ce     out  1        ALU clock enable
//  alu_rst    out  1        ALU sync reset pulse
//  alu_dout   in   DW       ALU result
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lock clear, rr pointer 0; takes effect mid-operation, in-flight result dropped.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//  IDLE: unlocked -> grant first valid requester at/after rr pointer; locked -> only owner eligible. req_ready[g]=1 for one cycle, operands latched.
//  ISSUE (1 cycle): alu_ce=1, alu_accload=~first, latched operands/signs driven; ce low in every other state.
//  WAIT: count LAT-1 further cycles; alu_dout sampled on last WAIT cycle (LAT=1: WAIT lasts 1 cycle) into rsp_data.
//  RESP: rsp_valid=1, rsp_data/rsp_id stable until rsp_ready; transfer on valid&ready -> IDLE same edge.
//  On transfer: last=1 -> clear lock, rr pointer = owner+1 mod NREQ; last=0 -> lock held by owner.
//  first=1 on a locked beat: accumulator reloads, lock unchanged. first=0 with no prior lock: accepted, accumulates onto stale value (caller error, not flagged).
//  Max throughput: one beat per LAT+3 cycles with rsp_ready held high.
//  alu_rst pulses only via watchdog; operands held after ISSUE.
// CONFIGURATION
//  ALU54D_SCHED_WATCHDOG_EN defined: 8-bit counter runs in IDLE while locked and owner req_valid=0; at TIMEOUT: lock cleared, rr advanced, alu_rst=1 and err_timeout=1 for one cycle (extra output err_timeout, 1 bit, reset 0).
//  Undefined: no counter, no err_timeout port, lock held indefinitely, alu_rst tied 0.
// STRUCTURE
//  Package alu54d_sched_pkg: DW constant, state enum {IDLE,ISSUE,WAIT,RESP}, beat struct {a,b,asign,bsign,first,last}.
//  Sub-module alu54d_rr_pick: combinational round-robin priority pick (valid mask, pointer -> one-hot grant, index).
// TESTING
//  Single beat: req0 a=0x1111 b=0x2 first=last=1, ALU model A+B -> rsp_data=0x1113, rsp_id=0, lock clear.
//  Burst: req1 beats (5,3,first) (7,1) (2,2,last) accumulating -> rsp 8,16,20; req0 valid throughout not granted until after third rsp.
//  Fairness: all 4 valid single beats, pointer 0 -> rsp_id order 0,1,2,3,0; none starved over 16 beats.
//  Backpressure: rsp_ready low 10 cycles -> rsp_valid/data/id stable, alu_ce stays 0, no req_ready.
//  Reset mid-WAIT: reset low during WAIT -> all outputs 0 immediately, no rsp after release, next grant from req0.
//  Watchdog (macro on, TIMEOUT=8): owner drops valid after non-last beat -> alu_rst and err_timeout pulse at 8th idle cycle, req2 then granted.

Source files
------------

// File: rtl/alu54d_sched_pkg.sv
// Shared types and helpers for the ALU54D accumulate scheduler.
package alu54d_sched_pkg;

  // Native ALU54D operand/result width
  localparam int ALU_DW = 54;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // One accepted beat as latched from the winning requester
  typedef struct packed {
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    logic              asign;
    logic              bsign;
    logic              first;
    logic              last;
  } beat_t;

  // Round-robin successor of requester index cur among n requesters
  function automatic int next_rr(input int cur, input int n);
    return (cur + 1) % n;
  endfunction

endpackage

// File: rtl/alu54d_rr_pick.sv
// Combinational round-robin pick: first set bit of valid at or after ptr,
// wrapping around; returns one-hot grant, its index and an any-flag.
module alu54d_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // cand[k] is the requester index k places after the pointer
  logic [IW-1:0] cand [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand[gi] = IW'((int'(ptr) + gi) % NREQ);
  end

  // Scan from farthest to nearest so the nearest valid candidate wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid[cand[k]]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
    grant = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu54d_acc_sched.sv
// Round-robin scheduler sharing one ALU54D accumulate datapath among NREQ
// requesters, with burst locking from first to last beat.
// Optional watchdog: define ALU54D_SCHED_WATCHDOG_EN to add the TIMEOUT
// parameter, the stall counter and the err_timeout output.
module alu54d_acc_sched
  import alu54d_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = ALU_DW,
`ifdef ALU54D_SCHED_WATCHDOG_EN
  parameter int TIMEOUT = 255,
`endif
  parameter int LAT     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DW-1:0]      req_a,
  input  logic [NREQ*DW-1:0]      req_b,
  input  logic [NREQ*2-1:0]       req_sign,
  input  logic [NREQ-1:0]         req_first,
  input  logic [NREQ-1:0]         req_last,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DW-1:0]           rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  output logic                    alu_asign,
  output logic                    alu_bsign,
  output logic                    alu_accload,
  output logic                    alu_ce,
  output logic                    alu_rst,
`ifdef ALU54D_SCHED_WATCHDOG_EN
  output logic                    err_timeout,
`endif
  input  logic [DW-1:0]           alu_dout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t          state_reg;
  beat_t           beat_reg;
  logic            locked_reg;
  logic [IW-1:0]   owner_reg;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   gnt_reg;
  logic [CW-1:0]   wait_reg;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [1:0]      pick_sign;

`ifdef ALU54D_SCHED_WATCHDOG_EN
  logic [7:0]      wd_reg;
  logic            wd_fire_reg;
`endif

  // While a burst holds the lock only its owner may be granted
  always_comb begin
    eligible = req_valid;
    if (locked_reg) begin
      eligible = req_valid & (NREQ'(1) << owner_reg);
    end
  end

  alu54d_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid (eligible),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign pick_sign = req_sign[pick_idx*2 +: 2];

  // Latched operands stay on the ALU pins after the issue cycle
  assign alu_a       = DW'(beat_reg.a);
  assign alu_b       = DW'(beat_reg.b);
  assign alu_asign   = beat_reg.asign;
  assign alu_bsign   = beat_reg.bsign;
  // Only meaningful while alu_ce is high; 0 outside the issue cycle
  assign alu_accload = (state_reg == ISSUE) && !beat_reg.first;

`ifdef ALU54D_SCHED_WATCHDOG_EN
  assign alu_rst     = wd_fire_reg;
  assign err_timeout = wd_fire_reg;
`else
  assign alu_rst     = 1'b0;
`endif

  // Scheduler FSM: grant, issue, wait for ALU result, hold response, track lock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      locked_reg <= 1'b0;
      owner_reg  <= '0;
      ptr_reg    <= '0;
      gnt_reg    <= '0;
      wait_reg   <= '0;
      req_ready  <= '0;
      alu_ce     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
`ifdef ALU54D_SCHED_WATCHDOG_EN
      wd_reg      <= '0;
      wd_fire_reg <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      alu_ce    <= 1'b0;
`ifdef ALU54D_SCHED_WATCHDOG_EN
      wd_reg      <= '0;
      wd_fire_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            req_ready      <= pick_grant;
            gnt_reg        <= pick_idx;
            beat_reg.a     <= ALU_DW'(req_a[pick_idx*DW +: DW]);
            beat_reg.b     <= ALU_DW'(req_b[pick_idx*DW +: DW]);
            beat_reg.asign <= pick_sign[0];
            beat_reg.bsign <= pick_sign[1];
            beat_reg.first <= req_first[pick_idx];
            beat_reg.last  <= req_last[pick_idx];
            alu_ce         <= 1'b1;
            state_reg      <= ISSUE;
          end
`ifdef ALU54D_SCHED_WATCHDOG_EN
          else if (locked_reg && !req_valid[owner_reg]) begin
            // Owner stalled mid-burst: after TIMEOUT idle cycles drop the lock
            if (wd_reg == 8'(TIMEOUT - 1)) begin
              wd_fire_reg <= 1'b1;
              locked_reg  <= 1'b0;
              ptr_reg     <= IW'(next_rr(int'(owner_reg), NREQ));
            end else begin
              wd_reg <= wd_reg + 8'd1;
            end
          end
`endif
        end
        ISSUE: begin
          wait_reg  <= CW'(LAT - 1);
          state_reg <= WAIT;
        end
        WAIT: begin
          if (wait_reg == '0) begin
            rsp_data  <= alu_dout;
            rsp_id    <= gnt_reg;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else begin
            wait_reg <= wait_reg - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
            if (beat_reg.last) begin
              locked_reg <= 1'b0;
              ptr_reg    <= IW'(next_rr(int'(gnt_reg), NREQ));
            end else begin
              locked_reg <= 1'b1;
              owner_reg  <= gnt_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu54d_acc_sched.sv
// Scoreboard bench for alu54d_acc_sched with a behavioural ALU stub
// (accumulator of A+B, one output register) and a round-robin/lock model.
`timescale 1ns/1ps
module tb_alu54d_acc_sched;

  localparam int NREQ = 4;
  localparam int DW   = 54;
  localparam int LAT  = 1;
  localparam int IW   = 2;
`ifdef ALU54D_SCHED_WATCHDOG_EN
  localparam int TIMEOUT = 8;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_a = '0;
  logic [NREQ*DW-1:0]   req_b = '0;
  logic [NREQ*2-1:0]    req_sign = '0;
  logic [NREQ-1:0]      req_first = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [DW-1:0]        rsp_data;
  logic [IW-1:0]        rsp_id;
  logic [DW-1:0]        alu_a, alu_b, alu_dout;
  logic                 alu_asign, alu_bsign, alu_accload, alu_ce, alu_rst;
`ifdef ALU54D_SCHED_WATCHDOG_EN
  logic                 err_timeout;
`endif

  always #5 clk = ~clk;

  alu54d_acc_sched #(
    .NREQ    (NREQ),
    .DW      (DW),
`ifdef ALU54D_SCHED_WATCHDOG_EN
    .TIMEOUT (TIMEOUT),
`endif
    .LAT     (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sign    (req_sign),
    .req_first   (req_first),
    .req_last    (req_last),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_asign   (alu_asign),
    .alu_bsign   (alu_bsign),
    .alu_accload (alu_accload),
    .alu_ce      (alu_ce),
    .alu_rst     (alu_rst),
`ifdef ALU54D_SCHED_WATCHDOG_EN
    .err_timeout (err_timeout),
`endif
    .alu_dout    (alu_dout)
  );

  // ALU stub: load or accumulate A+B on ce, registered output
  logic [DW-1:0] alu_acc = '0;
  always @(posedge clk) begin
    if (alu_rst) alu_acc <= '0;
    else if (alu_ce) alu_acc <= (alu_accload ? alu_acc : '0) + alu_a + alu_b;
  end
  assign alu_dout = alu_acc;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    sign;
    logic          first;
    logic          last;
  } tb_beat_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  tb_beat_t bq [NREQ][$];
  exp_t     exp_q[$];

  int checks = 0;
  int fails = 0;
  int tmo_events = 0;
  int tmo_seen = 0;

  // Reference model state (monitor-owned)
  bit            m_locked = 0;
  bit            m_busy = 0;
  bit            rst_checked = 0;
  int            m_owner = 0;
  int            m_ptr = 0;
  int            m_stall = 0;
  logic [DW-1:0] m_acc = '0;

  // Input snapshot from the previous falling edge = the decision cycle
  logic [NREQ-1:0]    s_valid = '0, s_first = '0, s_last = '0;
  logic [NREQ*DW-1:0] s_a = '0, s_b = '0;
  logic [NREQ*2-1:0]  s_sign = '0;
  logic               p_rsp_valid = 0, p_rsp_ready = 0;
  logic [DW-1:0]      p_rsp_data = '0;
  logic [IW-1:0]      p_rsp_id = '0;
  int                 mon_w;
  exp_t               mon_e;
  logic [DW-1:0]      mon_a, mon_b;

  bit rsp_rand = 0;
  bit rsp_hold_low = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  function automatic int rr_winner(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (tmo_events != tmo_seen) begin
      checks++;
      fails++;
      tmo_seen = tmo_events;
      $display("FAIL wait_bound: got expired want completed");
    end
    if (!reset) begin
      if (!rst_checked) begin
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'd0);
        check("rst_alu_ab", 64'(alu_a | alu_b), 64'd0);
        check("rst_alu_ctl", 64'({alu_asign, alu_bsign, alu_accload, alu_ce, alu_rst}), 64'd0);
        rst_checked = 1;
      end
      exp_q.delete();
      m_locked = 0;
      m_busy = 0;
      m_ptr = 0;
      m_stall = 0;
      p_rsp_valid = 0;
    end else begin
      rst_checked = 0;
`ifdef ALU54D_SCHED_WATCHDOG_EN
      if (err_timeout || alu_rst) begin
        check("wd_stall_cycles", 64'(m_stall), 64'(TIMEOUT));
        check("wd_pulse_pair", 64'(alu_rst), 64'(err_timeout));
        m_locked = 0;
        m_ptr = (m_owner + 1) % NREQ;
        m_acc = '0;
        m_stall = 0;
        $display("watchdog release owner=%0d", m_owner);
      end else if (m_locked && !m_busy && !req_valid[m_owner]) begin
        m_stall++;
        if (m_stall == TIMEOUT + 1) check("wd_overdue", 64'(m_stall), 64'(TIMEOUT));
      end else begin
        m_stall = 0;
      end
`else
      if (alu_rst) check("alu_rst_tied", 64'(alu_rst), 64'd0);
`endif
      if (req_ready != '0) begin
        check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        check("accept_while_busy", 64'(m_busy), 64'd0);
        mon_w = m_locked ? (s_valid[m_owner] ? m_owner : -1) : rr_winner(s_valid, m_ptr);
        check("grant", 64'(req_ready), (mon_w >= 0) ? (64'd1 << mon_w) : 64'd0);
        if (mon_w >= 0) begin
          mon_a = s_a[mon_w*DW +: DW];
          mon_b = s_b[mon_w*DW +: DW];
          check("issue_ce", 64'(alu_ce), 64'd1);
          check("issue_accload", 64'(alu_accload), 64'(!s_first[mon_w]));
          check("issue_a", 64'(alu_a), 64'(mon_a));
          check("issue_b", 64'(alu_b), 64'(mon_b));
          check("issue_sign", 64'({alu_bsign, alu_asign}), 64'(s_sign[mon_w*2 +: 2]));
          m_acc = (s_first[mon_w] ? '0 : m_acc) + mon_a + mon_b;
          mon_e.id = mon_w;
          mon_e.data = m_acc;
          mon_e.last = s_last[mon_w];
          exp_q.push_back(mon_e);
          m_busy = 1;
        end
      end
      if (rsp_valid) begin
        if (p_rsp_valid && !p_rsp_ready)
          check("bp_hold", 64'({rsp_id, rsp_data}), 64'({p_rsp_id, p_rsp_data}));
        if (!rsp_ready) check("bp_ce_low", 64'(alu_ce), 64'd0);
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rsp: got id=%0d data=0x%0h want none", rsp_id, rsp_data);
          end else begin
            mon_e = exp_q.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
            check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
            $display("rsp id=%0d data=0x%0h last=%0b", rsp_id, rsp_data, mon_e.last);
            if (mon_e.last) begin
              m_locked = 0;
              m_ptr = (mon_e.id + 1) % NREQ;
            end else begin
              m_locked = 1;
              m_owner = mon_e.id;
            end
            m_busy = 0;
          end
        end
      end
      p_rsp_valid = rsp_valid;
      p_rsp_ready = rsp_ready;
      p_rsp_data = rsp_data;
      p_rsp_id = rsp_id;
    end
    s_valid = req_valid;
    s_first = req_first;
    s_last = req_last;
    s_a = req_a;
    s_b = req_b;
    s_sign = req_sign;
  end

  function automatic tb_beat_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [1:0] sign, input logic first, input logic last);
    tb_beat_t t;
    t.a = a; t.b = b; t.sign = sign; t.first = first; t.last = last;
    return t;
  endfunction

  // Requester drivers: retire the head on req_ready, present the next head
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && bq[i].size() > 0) void'(bq[i].pop_front());
      if (bq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_a[i*DW +: DW] = bq[i][0].a;
        req_b[i*DW +: DW] = bq[i][0].b;
        req_sign[i*2 +: 2] = bq[i][0].sign;
        req_first[i] = bq[i][0].first;
        req_last[i] = bq[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
        req_a[i*DW +: DW] = '0;
        req_b[i*DW +: DW] = '0;
        req_sign[i*2 +: 2] = '0;
        req_first[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
    rsp_ready = rsp_hold_low ? 1'b0 : (rsp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_idle(input int budget);
    bit done;
    int n;
    done = 0;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
      @(negedge clk);
      #2;
      done = (exp_q.size() == 0) && !m_busy && (req_ready == '0);
      for (int i = 0; i < NREQ; i++) if (bq[i].size() > 0) done = 0;
    end
    if (!done) tmo_events++;
  endtask

  initial begin
    int n;
    int len;
    drive();
    repeat (3) step();
    reset = 1'b1;
    step();

    // Single beat
    bq[0].push_back(mk(DW'(64'h1111), DW'(64'h2), 2'b00, 1'b1, 1'b1));
    run_idle(50);

    // Burst on req1 while req0 waits
    bq[1].push_back(mk(DW'(5), DW'(3), 2'b01, 1'b1, 1'b0));
    bq[1].push_back(mk(DW'(7), DW'(1), 2'b10, 1'b0, 1'b0));
    bq[1].push_back(mk(DW'(2), DW'(2), 2'b11, 1'b0, 1'b1));
    bq[0].push_back(mk(DW'(9), DW'(9), 2'b00, 1'b1, 1'b1));
    run_idle(100);

    // Reset during WAIT: in-flight result dropped
    bq[2].push_back(mk(DW'(64'hABC), DW'(1), 2'b00, 1'b1, 1'b1));
    n = 0;
    do begin
      step();
      n++;
    end while (req_ready == '0 && n < 50);
    if (req_ready == '0) tmo_events++;
    step();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;

    // Fairness from pointer 0: four single beats per requester
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < NREQ; i++)
        bq[i].push_back(mk(DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}),
                           2'($urandom_range(0, 3)), 1'b1, 1'b1));
    run_idle(300);

    // Backpressure: result held for 10+ cycles while another requester waits
    bq[0].push_back(mk(DW'(100), DW'(23), 2'b00, 1'b1, 1'b1));
    bq[3].push_back(mk(DW'(40), DW'(2), 2'b00, 1'b1, 1'b1));
    rsp_hold_low = 1;
    repeat (14) step();
    rsp_hold_low = 0;
    run_idle(100);

    // Random bursts with random response backpressure
    rsp_rand = 1;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < 3; k++) begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++)
          bq[i].push_back(mk(DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}),
                             2'($urandom_range(0, 3)), (j == 0), (j == len - 1)));
      end
    end
    run_idle(3000);
    rsp_rand = 0;

`ifdef ALU54D_SCHED_WATCHDOG_EN
    // Owner abandons a burst; watchdog releases the lock to req2
    bq[1].push_back(mk(DW'(11), DW'(4), 2'b00, 1'b1, 1'b0));
    run_idle(50);
    bq[2].push_back(mk(DW'(6), DW'(6), 2'b00, 1'b1, 1'b1));
    run_idle(100);
`endif

    repeat (3) @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
